dsconv_block_scheduler: RTL and testbench
=========================================

# dsconv_block_scheduler

Sequences one depthwise-separable conv block's input frame through the 7×7 window line buffer, one channel at a time. Streams each channel from feature-map memory in column-major order (row fastest) and clears the line buffer between channels. Feeds the alignment lead pixel, applies downstream stall with a one-entry skid, and counts/validates produced windows. Sits between the feature-map SRAM and the line buffer / depthwise MAC array.

## Interface
- H, 70, rows per channel (row index fastest)
- W, 186, columns per channel
- K, 7, window size; expected windows/channel NWIN = (H-K+1)*(W-K+1) = 11520
- C, 16, channels per frame
- PIX_W, 18, signed pixel width
- ADDR_W, 18, memory address width (≥ clog2(C*H*W))
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- frame_start  in  1  one-cycle pulse; starts a frame when idle, ignored when busy
- stall  in  1  downstream hold; while high no pixel enters the line buffer
- mem_rd_en  out  1  read strobe; data returns exactly 1 cycle later
- mem_addr  out  ADDR_W  read address = ch*H*W + col*H + row
- mem_rd_data  in  PIX_W  read data
- lb_rst  out  1  active-high synchronous clear to line buffer
- lb_start  out  1  shift enable to line buffer
- lb_pixel  out  PIX_W  pixel to line buffer (signed)
- lb_ready  in  1  line buffer window-valid (registered, holds when not shifting)
- ch_idx  out  clog2(C)  channel in progress
- win_count  out  16  windows counted in current channel
- busy  out  1  high from frame_start accept to done
- done  out  1  one-cycle pulse at frame end
- err  out  1  sticky: some channel ended with win_count ≠ NWIN; cleared on frame_start accept

## Operation
- States: IDLE, CLR, LEAD, FEED, DRAIN, DONE.
- IDLE: frame_start → CLR; busy=1; ch_idx=0; mem_addr=0; err=0.
- CLR (1 cycle): lb_rst=1; win_count=0. → LEAD.
- LEAD: lb_start=1, lb_pixel=0; mem_rd_en=1 for channel's first address. Stall held in LEAD without shifting or reading. → FEED.
- FEED: read pipeline flag rd_v set one cycle after each mem_rd_en.
  - Pixel source: skid if skid_v, else mem_rd_data when rd_v.
  - lb_start = (skid_v | rd_v) & ~stall; lb_pixel = selected pixel, else 0.
  - If rd_v & stall, capture mem_rd_data into skid, set skid_v. Skid is cleared when presented.
  - mem_rd_en = ~stall & ~(skid_v & rd_v) & reads_left. mem_addr increments by 1 per issued read.
  - After H*W pixels have been presented → DRAIN.
- DRAIN (1 cycle): counts final lb_ready; err |= (win_count ≠ NWIN). If ch_idx<C-1, ch_idx++ → CLR; else → DONE.
- DONE: done=1 for one cycle; busy=0. → IDLE.
- Window counting: win_count++ when lb_ready=1 and lb_start was 1 in the previous cycle; saturates at 0xFFFF.
- Line buffer is held cleared (lb_rst=1) in IDLE, DONE and during reset.

## Timing
- Reset values: mem_rd_en=0, mem_addr=0, lb_rst=1, lb_start=0, lb_pixel=0, ch_idx=0, win_count=0, busy=0, done=0, err=0; state=IDLE.
- Reset mid-frame: immediate abort to IDLE with reset values. No done pulse. Memory data returning after reset is discarded.
- Stall-free channel: CLR 1 + LEAD 1 + FEED H*W (13020) + DRAIN 1 = 13023 cycles. Frame: C*13023 cycles, then done on the next cycle.
- No bubble after stall release: the skid pixel and the next read's issue occur in the same cycle.
- Each stall cycle adds exactly one cycle; pixel order and values are unchanged.
- frame_start coincident with done, or while busy: ignored.
- Stall during CLR or DRAIN: no effect on those states.

## Test plan
- Reset, then frame_start with C=1, memory[a]=a, no stall → lb_pixel sequence 0 (lead), 0, 1, …, 13019; win_count=11520 at DRAIN; done at cycle 13024 after start; err=0.
- C=2 → lb_rst high exactly once between channels; second channel addresses 13020..26039; ch_idx 0→1; done pulses once.
- Random stall (30%, including stall on the cycle data returns) → lb_pixel sequence identical to the no-stall case; total cycles = 13023 + number of FEED stall cycles.
- Model lb_ready forced low for 5 windows → err=1 after DRAIN and remains 1 until the next frame_start; done still pulses.
- Deassert rst at FEED pixel 5000, then re-release rst → all outputs at reset values; a new frame_start gives a clean full channel with correct counts.
- frame_start pulses while busy and on the done cycle → ignored; only one frame is processed.

Source files
------------

// File: rtl/dsconv_block_scheduler.sv
// dsconv_block_scheduler: walks one conv block frame channel by channel
// into the 7x7 window line buffer with lead pixel, stall skid and window check.
module dsconv_block_scheduler #(
   parameter int H      = 70,
   parameter int W      = 186,
   parameter int K      = 7,
   parameter int C      = 16,
   parameter int PIX_W  = 18,
   parameter int ADDR_W = 18,
   parameter int CH_W   = (C > 1) ? $clog2(C) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    frame_start,
   input  logic                    stall,
   output logic                    mem_rd_en,
   output logic [ADDR_W-1:0]       mem_addr,
   input  logic signed [PIX_W-1:0] mem_rd_data,
   output logic                    lb_rst,
   output logic                    lb_start,
   output logic signed [PIX_W-1:0] lb_pixel,
   input  logic                    lb_ready,
   output logic [CH_W-1:0]         ch_idx,
   output logic [15:0]             win_count,
   output logic                    busy,
   output logic                    done,
   output logic                    err
);

   localparam int NPIX  = H * W;
   localparam int NWIN  = (H - K + 1) * (W - K + 1);
   localparam int CNT_W = $clog2(NPIX + 1);

   localparam logic [CNT_W-1:0]  NPIX_C  = CNT_W'(NPIX);
   localparam logic [CNT_W-1:0]  ONE_C   = CNT_W'(1);
   localparam logic [15:0]       NWIN_C  = 16'(NWIN);
   localparam logic [CH_W-1:0]   CH_LAST = CH_W'(C - 1);
   localparam logic [ADDR_W-1:0] ADDR_1  = ADDR_W'(1);

   typedef enum logic [2:0] {
      IDLE,
      CLR,
      LEAD,
      FEED,
      DRAIN,
      DONE
   } state_t;

   state_t state;

   // reads still to issue and pixels still to present in this channel
   logic [CNT_W-1:0] rd_left;
   logic [CNT_W-1:0] px_left;

   // rd_v: memory data is on mem_rd_data this cycle
   logic rd_v;
   logic skid_v;
   logic signed [PIX_W-1:0] skid;

   // line buffer shifted last cycle, so lb_ready now reflects a new window
   logic prev_start;

   logic        has_pix;
   logic        win_inc;
   logic        counting;
   logic [15:0] wc_nxt;

   // line buffer is cleared whenever no channel is being streamed
   assign lb_rst = (state == IDLE) | (state == CLR) | (state == DONE);

   // read strobe, shift enable and pixel mux follow stall without delay
   always_comb begin
      has_pix   = skid_v | rd_v;
      mem_rd_en = 1'b0;
      lb_start  = 1'b0;
      lb_pixel  = '0;
      unique case (state)
         LEAD: begin
            mem_rd_en = ~stall;
            lb_start  = ~stall;
         end
         FEED: begin
            mem_rd_en = ~stall & ~(skid_v & rd_v)
                      & (rd_left != '0);
            lb_start  = has_pix & ~stall;
            if (lb_start) begin
               lb_pixel = skid_v ? skid : mem_rd_data;
            end
         end
         default: begin
            mem_rd_en = 1'b0;
         end
      endcase
   end

   // a window counts once, in the cycle after the shift that produced it
   always_comb begin
      counting = (state == LEAD) | (state == FEED)
               | (state == DRAIN);
      win_inc  = counting & prev_start & lb_ready;
      wc_nxt   = win_count;
      if (win_inc && (win_count != 16'hFFFF)) begin
         wc_nxt = win_count + 16'd1;
      end
   end

   // frame and channel sequencing with registered status outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         mem_addr  <= '0;
         ch_idx    <= '0;
         win_count <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         rd_left   <= '0;
         px_left   <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (frame_start) begin
                  state    <= CLR;
                  busy     <= 1'b1;
                  ch_idx   <= '0;
                  mem_addr <= '0;
                  err      <= 1'b0;
               end
            end
            CLR: begin
               win_count <= '0;
               state     <= LEAD;
            end
            LEAD: begin
               win_count <= wc_nxt;
               if (!stall) begin
                  mem_addr <= mem_addr + ADDR_1;
                  rd_left  <= NPIX_C - ONE_C;
                  px_left  <= NPIX_C;
                  state    <= FEED;
               end
            end
            FEED: begin
               win_count <= wc_nxt;
               if (mem_rd_en) begin
                  mem_addr <= mem_addr + ADDR_1;
                  rd_left  <= rd_left - ONE_C;
               end
               if (lb_start) begin
                  px_left <= px_left - ONE_C;
                  if (px_left == ONE_C) begin
                     state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               win_count <= wc_nxt;
               err       <= err | (wc_nxt != NWIN_C);
               if (ch_idx == CH_LAST) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  ch_idx <= ch_idx + CH_W'(1);
                  state  <= CLR;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // read-return flag, one-entry skid and last-cycle shift flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_v       <= 1'b0;
         skid_v     <= 1'b0;
         skid       <= '0;
         prev_start <= 1'b0;
      end else begin
         rd_v       <= mem_rd_en;
         prev_start <= lb_start;
         if (rd_v & (stall | skid_v)) begin
            skid   <= mem_rd_data;
            skid_v <= 1'b1;
         end else if (lb_start) begin
            skid_v <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_dsconv_block_scheduler.sv
// tb_dsconv_block_scheduler: reduced-size frames against a memory, line
// buffer and pixel-order model built from the block's streaming rules.
module tb_dsconv_block_scheduler;

   localparam int H      = 12;
   localparam int W      = 10;
   localparam int K      = 7;
   localparam int C      = 3;
   localparam int PIX_W  = 18;
   localparam int ADDR_W = 18;
   localparam int NPIX   = H * W;
   localparam int NWIN   = (H - K + 1) * (W - K + 1);
   localparam int MEMN   = C * NPIX;
   localparam int EXP_DUR = C * (NPIX + 3) + 1;
   localparam int BOUND  = EXP_DUR * 4 + 100;
   localparam logic [59:0] RST_V =
      {1'b0, 18'd0, 1'b1, 1'b0, 18'd0, 2'd0, 16'd0, 3'b000};

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    frame_start;
   logic                    stall;
   logic                    mem_rd_en;
   logic [ADDR_W-1:0]       mem_addr;
   logic signed [PIX_W-1:0] mem_rd_data = '0;
   logic                    lb_rst;
   logic                    lb_start;
   logic signed [PIX_W-1:0] lb_pixel;
   logic                    lb_ready = 1'b0;
   logic [1:0]              ch_idx;
   logic [15:0]             win_count;
   logic                    busy;
   logic                    done;
   logic                    err;

   dsconv_block_scheduler #(
      .H(H), .W(W), .K(K), .C(C),
      .PIX_W(PIX_W), .ADDR_W(ADDR_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .frame_start(frame_start),
      .stall(stall),
      .mem_rd_en(mem_rd_en),
      .mem_addr(mem_addr),
      .mem_rd_data(mem_rd_data),
      .lb_rst(lb_rst),
      .lb_start(lb_start),
      .lb_pixel(lb_pixel),
      .lb_ready(lb_ready),
      .ch_idx(ch_idx),
      .win_count(win_count),
      .busy(busy),
      .done(done),
      .err(err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic signed [PIX_W-1:0] mem [MEMN];
   logic signed [PIX_W-1:0] got_q [$];
   int wc_log [$];
   int ch_log [$];

   logic s_rd = 1'b0;
   logic [ADDR_W-1:0] s_addr = '0;
   logic s_start = 1'b0;
   logic signed [PIX_W-1:0] s_pix = '0;
   logic s_lbrst = 1'b1;
   logic prev_lbrst = 1'b1;

   int  ch_shifts = 0;
   int  mask_left = 0;
   bit  in_frame = 1'b0;
   bit  first = 1'b0;
   int  stall_cyc, bubbles, stall_viol, busy_drop, clr_cyc;
   int  done_cnt, done_total = 0;
   logic err_at_done, err_first;

   // sample DUT outputs mid-cycle and gather frame statistics
   always @(negedge clk) begin
      s_rd    = mem_rd_en;
      s_addr  = mem_addr;
      s_start = lb_start;
      s_pix   = lb_pixel;
      s_lbrst = lb_rst;
      if (done) done_total++;
      if (in_frame) begin
         if (first) begin
            err_first = err;
            first = 1'b0;
         end
         if (!lb_rst && ch_shifts < NPIX + 1) begin
            if (stall) stall_cyc++;
            else if (!lb_start) bubbles++;
            if (stall && (lb_start || mem_rd_en)) stall_viol++;
         end
         if (!busy && !done) busy_drop++;
         if (lb_rst && !done) clr_cyc++;
         if ((lb_rst && !prev_lbrst && !done) || done) begin
            wc_log.push_back(int'(win_count));
            ch_log.push_back(int'(ch_idx));
         end
         if (done) begin
            done_cnt++;
            err_at_done = err;
         end
      end
      prev_lbrst = lb_rst;
   end

   // memory with one-cycle read latency and a window-valid line buffer
   always @(posedge clk) begin
      int p;
      bit v;
      if (s_rd && int'(s_addr) < MEMN) mem_rd_data <= mem[s_addr];
      else mem_rd_data <= PIX_W'($urandom);
      if (s_lbrst) begin
         ch_shifts = 0;
         lb_ready <= 1'b0;
      end else if (s_start) begin
         got_q.push_back(s_pix);
         p = ch_shifts - 1;
         v = (p >= 0) && (p % H >= K - 1) && (p / H >= K - 1);
         if (v && mask_left > 0) begin
            v = 1'b0;
            mask_left--;
         end
         lb_ready <= v;
         ch_shifts++;
      end
   end

   function automatic int pix_bad();
      int nb = 0;
      int k = 0;
      logic signed [PIX_W-1:0] e;
      for (int c = 0; c < C; c++) begin
         for (int j = 0; j <= NPIX; j++) begin
            e = (j == 0) ? '0 : mem[c * NPIX + j - 1];
            if (k >= got_q.size() || got_q[k] !== e) nb++;
            k++;
         end
      end
      return nb;
   endfunction

   function automatic int wc_bad(input int nmask);
      int nb = 0;
      int e;
      for (int c = 0; c < C; c++) begin
         e = (c == 0) ? NWIN - nmask : NWIN;
         if (c >= wc_log.size() || wc_log[c] != e) nb++;
         if (c >= ch_log.size() || ch_log[c] != ((c + 1 < C) ? c + 1 : C - 1)) nb++;
      end
      return nb;
   endfunction

   task automatic fill_mem(input bit ident);
      for (int a = 0; a < MEMN; a++)
         mem[a] = ident ? PIX_W'(a) : PIX_W'($urandom);
   endtask

   task automatic run_frame(input int pct, input int nmask,
                            input bit ident, input bit poke,
                            output int dur);
      int n;
      bit fin;
      fill_mem(ident);
      got_q.delete();
      wc_log.delete();
      ch_log.delete();
      stall_cyc = 0; bubbles = 0; stall_viol = 0;
      busy_drop = 0; clr_cyc = 0; done_cnt = 0;
      err_at_done = 1'bx;
      first = 1'b1;
      mask_left = nmask;
      @(posedge clk); #1 frame_start = 1'b1; stall = 1'b0;
      @(posedge clk); #1 frame_start = 1'b0; in_frame = 1'b1;
      n = 1;
      fin = 1'b0;
      dur = -1;
      while (!fin && n <= BOUND) begin
         stall = (pct > 0) && (int'($urandom_range(99)) < pct);
         frame_start = poke && (n == 40 || n == EXP_DUR);
         @(negedge clk);
         if (done) begin
            fin = 1'b1;
            dur = n;
         end
         @(posedge clk); #1;
         n++;
      end
      frame_start = 1'b0;
      stall = 1'b0;
      in_frame = 1'b0;
      if (!fin) begin
         checks++;
         errors++;
         $display("FAIL frame_timeout: no done within %0d cycles", BOUND);
      end
   endtask

   task automatic test_reset();
      logic [59:0] obs;
      @(negedge clk);
      obs = {mem_rd_en, mem_addr, lb_rst, lb_start, lb_pixel,
             ch_idx, win_count, busy, done, err};
      checks++;
      if (obs !== RST_V) begin
         errors++;
         $display("FAIL reset_values: got %h expected %h", obs, RST_V);
      end
      @(posedge clk); #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      obs = {mem_rd_en, mem_addr, lb_rst, lb_start, lb_pixel,
             ch_idx, win_count, busy, done, err};
      checks++;
      if (obs !== RST_V) begin
         errors++;
         $display("FAIL idle_values: got %h expected %h", obs, RST_V);
      end
   endtask

   task automatic test_basic();
      int dur, nb;
      run_frame(0, 0, 1'b1, 1'b0, dur);
      checks++;
      if (dur != EXP_DUR) begin
         errors++;
         $display("FAIL basic_latency: got %0d expected %0d", dur, EXP_DUR);
      end
      checks++;
      if (got_q.size() != C * (NPIX + 1)) begin
         errors++;
         $display("FAIL basic_pix_count: got %0d expected %0d",
                  got_q.size(), C * (NPIX + 1));
      end
      nb = pix_bad();
      checks++;
      if (nb != 0) begin
         errors++;
         $display("FAIL basic_pix_values: %0d wrong, expected 0", nb);
      end
      nb = wc_bad(0);
      checks++;
      if (nb != 0) begin
         errors++;
         $display("FAIL basic_win_ch: %0d wrong, expected 0", nb);
      end
      checks++;
      if (clr_cyc != C) begin
         errors++;
         $display("FAIL basic_lb_rst: got %0d expected %0d", clr_cyc, C);
      end
      checks++;
      if (done_cnt != 1 || busy_drop != 0) begin
         errors++;
         $display("FAIL basic_done_busy: got %0d/%0d expected 1/0",
                  done_cnt, busy_drop);
      end
      checks++;
      if (err_at_done !== 1'b0) begin
         errors++;
         $display("FAIL basic_err: got %b expected 0", err_at_done);
      end
   endtask

   task automatic test_random_stall();
      int dur, nb;
      int pcts [2] = '{30, 50};
      foreach (pcts[i]) begin
         run_frame(pcts[i], 0, 1'b0, 1'b0, dur);
         checks++;
         if (dur != EXP_DUR + stall_cyc) begin
            errors++;
            $display("FAIL stall_latency: got %0d expected %0d",
                     dur, EXP_DUR + stall_cyc);
         end
         nb = pix_bad();
         checks++;
         if (nb != 0 || got_q.size() != C * (NPIX + 1)) begin
            errors++;
            $display("FAIL stall_pixels: %0d wrong of %0d, expected 0",
                     nb, got_q.size());
         end
         checks++;
         if (bubbles != 0 || stall_viol != 0) begin
            errors++;
            $display("FAIL stall_flow: got %0d/%0d expected 0/0",
                     bubbles, stall_viol);
         end
         nb = wc_bad(0);
         checks++;
         if (nb != 0 || err_at_done !== 1'b0) begin
            errors++;
            $display("FAIL stall_windows: %0d wrong err %b, expected 0 0",
                     nb, err_at_done);
         end
      end
   endtask

   task automatic test_err_mask();
      int dur;
      run_frame(0, 5, 1'b0, 1'b0, dur);
      checks++;
      if (err_at_done !== 1'b1) begin
         errors++;
         $display("FAIL err_set: got %b expected 1", err_at_done);
      end
      checks++;
      if (wc_log.size() < 2 || wc_log[0] != NWIN - 5 || wc_log[1] != NWIN) begin
         errors++;
         $display("FAIL err_counts: got %0d entries expected %0d then %0d",
                  wc_log.size(), NWIN - 5, NWIN);
      end
      checks++;
      if (done_cnt != 1) begin
         errors++;
         $display("FAIL err_done: got %0d expected 1", done_cnt);
      end
      repeat (10) @(posedge clk);
      @(negedge clk);
      checks++;
      if (err !== 1'b1) begin
         errors++;
         $display("FAIL err_sticky: got %b expected 1", err);
      end
      run_frame(20, 0, 1'b0, 1'b0, dur);
      checks++;
      if (err_first !== 1'b0 || err_at_done !== 1'b0) begin
         errors++;
         $display("FAIL err_clear: got %b/%b expected 0/0",
                  err_first, err_at_done);
      end
   endtask

   task automatic test_reset_midframe();
      int n, sz, dur, nb;
      logic [59:0] obs;
      fill_mem(1'b0);
      got_q.delete();
      mask_left = 0;
      @(posedge clk); #1 frame_start = 1'b1;
      @(posedge clk); #1 frame_start = 1'b0;
      n = 0;
      while (got_q.size() < 51 && n < 1000) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (got_q.size() < 51) begin
         errors++;
         $display("FAIL rst_reach: got %0d pixels expected 51", got_q.size());
      end
      sz = got_q.size();
      rst = 1'b0;
      @(negedge clk);
      obs = {mem_rd_en, mem_addr, lb_rst, lb_start, lb_pixel,
             ch_idx, win_count, busy, done, err};
      checks++;
      if (obs !== RST_V) begin
         errors++;
         $display("FAIL rst_abort: got %h expected %h", obs, RST_V);
      end
      @(posedge clk); #1;
      @(posedge clk); #1 rst = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      obs = {mem_rd_en, mem_addr, lb_rst, lb_start, lb_pixel,
             ch_idx, win_count, busy, done, err};
      checks++;
      if (obs !== RST_V || got_q.size() != sz) begin
         errors++;
         $display("FAIL rst_quiet: got %h/%0d expected %h/%0d",
                  obs, got_q.size(), RST_V, sz);
      end
      run_frame(0, 0, 1'b0, 1'b0, dur);
      nb = pix_bad() + wc_bad(0);
      checks++;
      if (dur != EXP_DUR || nb != 0 || err_at_done !== 1'b0) begin
         errors++;
         $display("FAIL rst_recover: dur %0d bad %0d err %b expected %0d 0 0",
                  dur, nb, err_at_done, EXP_DUR);
      end
   endtask

   task automatic test_ignore();
      int dur, d0;
      d0 = done_total;
      run_frame(0, 0, 1'b1, 1'b1, dur);
      checks++;
      if (dur != EXP_DUR) begin
         errors++;
         $display("FAIL ign_latency: got %0d expected %0d", dur, EXP_DUR);
      end
      repeat (30) @(posedge clk);
      @(negedge clk);
      checks++;
      if (done_total - d0 != 1) begin
         errors++;
         $display("FAIL ign_done: got %0d expected 1", done_total - d0);
      end
      checks++;
      if (busy !== 1'b0 || lb_rst !== 1'b1) begin
         errors++;
         $display("FAIL ign_idle: got busy %b lb_rst %b expected 0 1",
                  busy, lb_rst);
      end
   endtask

   initial begin
      rst = 1'b0;
      frame_start = 1'b0;
      stall = 1'b0;
      repeat (3) @(posedge clk);
      test_reset();
      test_basic();
      test_random_stall();
      test_err_mask();
      test_reset_midframe();
      test_ignore();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
